// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with fixed or round-robin
// arbitration and a one-deep valid/ready output stage.
//
// Fixed mode: the highest set request index wins.
// Round-robin mode: the search starts at a rotating pointer and wraps at WIDTH-1.
//
// Optional build macro PRIO_ENC_EMPTY_CNT_EN adds a 16-bit saturating count
// of accepted all-zero request vectors on output empty_cnt.
module prio_encoder_rr #(
    parameter int WIDTH     = 8,
    parameter int WIDTH_OUT = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     d,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] out_idx,
    output logic [WIDTH-1:0]     out_onehot,
    output logic                 out_none
`ifdef PRIO_ENC_EMPTY_CNT_EN
    ,
    output logic [15:0]          empty_cnt
`endif
);

    // Index of the highest set bit (0 when the vector is empty).
    function automatic logic [WIDTH_OUT-1:0] highest_idx(input logic [WIDTH-1:0] v);
        logic [WIDTH_OUT-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = WIDTH_OUT'(i);
        end
        return idx;
    endfunction

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [WIDTH_OUT-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [WIDTH_OUT-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = WIDTH_OUT'(i);
        end
        return idx;
    endfunction

    // Mask selecting request positions at or above the round-robin pointer.
    function automatic logic [WIDTH-1:0] upper_mask(input logic [WIDTH_OUT-1:0] p);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i >= int'(p));
        end
        return m;
    endfunction

    // One-hot decode of an index into a WIDTH-bit grant.
    function automatic logic [WIDTH-1:0] decode(input logic [WIDTH_OUT-1:0] idx);
        logic [WIDTH-1:0] oh;
        oh = '0;
        for (int i = 0; i < WIDTH; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

    logic                 valid_q, valid_d;
    logic [WIDTH_OUT-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]     onehot_q, onehot_d;
    logic                 none_q, none_d;
    logic [WIDTH_OUT-1:0] ptr_q, ptr_d;

    logic                 accept;
    logic                 req_any;
    logic [WIDTH-1:0]     req_upper;
    logic [WIDTH_OUT-1:0] win_rr;
    logic [WIDTH_OUT-1:0] win_idx;
    logic [WIDTH_OUT-1:0] ptr_adv;

    // The result register can take a new beat when empty or being drained.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign req_any  = |d;

    // Round-robin: prefer requests at/above the pointer, else wrap to the
    // lowest request overall. Pointer advance wraps at WIDTH-1, not at
    // 2^WIDTH_OUT, so non-power-of-2 widths stay in range.
    always_comb begin
        req_upper = d & upper_mask(ptr_q);
        win_rr    = (|req_upper) ? lowest_idx(req_upper) : lowest_idx(d);
        win_idx   = mode ? win_rr : highest_idx(d);
        ptr_adv   = (win_idx == WIDTH_OUT'(WIDTH - 1)) ? '0 : win_idx + WIDTH_OUT'(1);
    end

    // Next-state for the result stage and pointer; everything holds by default,
    // which also covers backpressure (valid && !out_ready).
    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        none_d   = none_q;
        ptr_d    = ptr_q;
        if (accept) begin
            valid_d = 1'b1;
            if (req_any) begin
                idx_d    = win_idx;
                onehot_d = decode(win_idx);
                none_d   = 1'b0;
                if (mode) ptr_d = ptr_adv;
            end else begin
                idx_d    = '0;
                onehot_d = '0;
                none_d   = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result and pointer registers; asynchronous reset drops any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            none_q   <= 1'b0;
            ptr_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            none_q   <= none_d;
            ptr_q    <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_none   = none_q;

`ifdef PRIO_ENC_EMPTY_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of accepted empty request vectors.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !req_any && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Empty-beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign empty_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Testbench for prio_encoder_rr: WIDTH=8 and WIDTH=5 instances share the
// handshake controls; a behavioural model predicts every output each cycle.
`timescale 1ns/1ps
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] d8 = '0;
    logic [4:0] d5 = '0;

    logic       in_ready8, out_valid8, out_none8;
    logic [2:0] out_idx8;
    logic [7:0] out_onehot8;
    logic       in_ready5, out_valid5, out_none5;
    logic [2:0] out_idx5;
    logic [4:0] out_onehot5;
`ifdef PRIO_ENC_EMPTY_CNT_EN
    logic [15:0] empty_cnt8, empty_cnt5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .d(d8), .mode(mode), .out_valid(out_valid8), .out_ready(out_ready),
        .out_idx(out_idx8), .out_onehot(out_onehot8), .out_none(out_none8)
`ifdef PRIO_ENC_EMPTY_CNT_EN
        , .empty_cnt(empty_cnt8)
`endif
    );

    prio_encoder_rr #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
        .d(d5), .mode(mode), .out_valid(out_valid5), .out_ready(out_ready),
        .out_idx(out_idx5), .out_onehot(out_onehot5), .out_none(out_none5)
`ifdef PRIO_ENC_EMPTY_CNT_EN
        , .empty_cnt(empty_cnt5)
`endif
    );

    typedef struct packed {
        bit          valid;
        int          idx;
        logic [63:0] oh;
        bit          none;
        int          ptr;
        int          cnt;
    } mstate_t;

    mstate_t m8, m5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rules: -1 when nothing is requested.
    function automatic int pick(input logic [63:0] v, input int w, input bit m, input int p);
        if (!m) begin
            for (int i = w - 1; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int k = 0; k < w; k++) if (v[(p + k) % w]) return (p + k) % w;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [63:0] v, input int w);
        mstate_t n;
        int win;
        n = s;
        if (in_valid && (!s.valid || out_ready)) begin
            win = pick(v, w, mode, s.ptr);
            n.valid = 1'b1;
            if (win < 0) begin
                n.idx  = 0;
                n.oh   = '0;
                n.none = 1'b1;
                if (n.cnt < 65535) n.cnt = n.cnt + 1;
            end else begin
                n.idx  = win;
                n.oh   = 64'd1 << win;
                n.none = 1'b0;
                if (mode) n.ptr = (win + 1) % w;
            end
        end else if (out_ready) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8 <= '0;
            m5 <= '0;
        end else begin
            m8 <= model_next(m8, 64'(d8), 8);
            m5 <= model_next(m5, 64'(d5), 5);
        end
    end

    task automatic compare_one(input string t, input mstate_t m, input bit rdy, input bit v,
                               input int idx, input logic [63:0] oh, input bit none, input int cnt);
        chk({t, "_in_ready"}, 64'(rdy), 64'(!m.valid || out_ready));
        chk({t, "_out_valid"}, 64'(v), 64'(m.valid));
        if (m.valid) begin
            chk({t, "_out_idx"}, 64'(idx), 64'(m.idx));
            chk({t, "_out_onehot"}, oh, m.oh);
            chk({t, "_out_none"}, 64'(none), 64'(m.none));
            chk({t, "_invariant"}, 64'(($countones(oh) <= 1) && (none == (oh == 0))), 64'd1);
        end
`ifdef PRIO_ENC_EMPTY_CNT_EN
        chk({t, "_empty_cnt"}, 64'(cnt), 64'(m.cnt));
`endif
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            int c8, c5;
            c8 = 0;
            c5 = 0;
`ifdef PRIO_ENC_EMPTY_CNT_EN
            c8 = int'(empty_cnt8);
            c5 = int'(empty_cnt5);
`endif
            compare_one("w8", m8, in_ready8, out_valid8, int'(out_idx8), 64'(out_onehot8), out_none8, c8);
            compare_one("w5", m5, in_ready5, out_valid5, int'(out_idx5), 64'(out_onehot5), out_none5, c5);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid8), 64'd0);
        chk("rst_idx", 64'(out_idx8), 64'd0);
        chk("rst_onehot", 64'(out_onehot8), 64'd0);
        chk("rst_none", 64'(out_none8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fixed mode
        in_valid = 1'b1; mode = 1'b0; out_ready = 1'b1; d8 = 8'b0100_1010;
        tick();
        chk("fix_idx", 64'(out_idx8), 64'd6);
        chk("fix_onehot", 64'(out_onehot8), 64'h40);
        chk("fix_none", 64'(out_none8), 64'd0);
        d8 = 8'h00;
        tick();
        chk("zero_none", 64'(out_none8), 64'd1);
        chk("zero_idx", 64'(out_idx8), 64'd0);
        chk("zero_onehot", 64'(out_onehot8), 64'd0);

        // Round-robin rotation over all-ones, then sparse vector
        mode = 1'b1; d8 = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_ff_idx", 64'(out_idx8), 64'(k % 8));
        end
        chk("model_ptr_after_ff", 64'(m8.ptr), 64'd1);
        d8 = 8'b0000_0101;
        tick(); chk("rr_05_a", 64'(out_idx8), 64'd2);
        tick(); chk("rr_05_b", 64'(out_idx8), 64'd0);
        tick(); chk("rr_05_c", 64'(out_idx8), 64'd2);

        // Backpressure
        mode = 1'b0; d8 = 8'h10;
        tick(); chk("bp_first", 64'(out_idx8), 64'd4);
        out_ready = 1'b0; d8 = 8'h01;
        #1 chk("bp_ready_low", 64'(in_ready8), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_idx", 64'(out_idx8), 64'd4);
            chk("bp_hold_ready", 64'(in_ready8), 64'd0);
            chk("bp_hold_valid", 64'(out_valid8), 64'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_ready_high", 64'(in_ready8), 64'd1);
        tick();
        chk("bp_release_idx", 64'(out_idx8), 64'd0);
        chk("bp_release_valid", 64'(out_valid8), 64'd1);

        // WIDTH=5 round-robin wrap at 4
        mode = 1'b1; d5 = 5'b01000;
        tick(); chk("w5_idx3", 64'(out_idx5), 64'd3);
        d5 = 5'b10001;
        tick(); chk("w5_idx4", 64'(out_idx5), 64'd4);
        tick(); chk("w5_wrap_idx0", 64'(out_idx5), 64'd0);
        d5 = 5'b00011;
        tick(); chk("w5_ptr1_idx1", 64'(out_idx5), 64'd1);

        // Asynchronous reset mid-stream
        d8 = 8'h04; d5 = '0;
        tick();
        chk("pre_rst_idx", 64'(out_idx8), 64'd2);
        chk("model_ptr3", 64'(m8.ptr), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid8), 64'd0);
        chk("arst_idx", 64'(out_idx8), 64'd0);
        chk("arst_onehot", 64'(out_onehot8), 64'd0);
        chk("arst_none", 64'(out_none8), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; mode = 1'b1; d8 = 8'hFF;
        tick();
        chk("post_rst_rr_idx", 64'(out_idx8), 64'd0);

        // Randomized traffic, checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            int r;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            mode      = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            if (r == 0) d8 = '0;
            else if (r == 1) d8 = 8'd1 << $urandom_range(0, 7);
            else d8 = 8'($urandom);
            r = $urandom_range(0, 3);
            if (r == 0) d5 = '0;
            else if (r == 1) d5 = 5'd1 << $urandom_range(0, 4);
            else d5 = 5'($urandom);
            tick();
        end

`ifdef PRIO_ENC_EMPTY_CNT_EN
        // Empty-beat counter and saturation
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0;
        d8 = 8'h00; d5 = 5'h00;
        tick(); tick(); tick();
        d8 = 8'h81; d5 = 5'h03;
        tick(); tick();
        chk("cnt_three", 64'(empty_cnt8), 64'd3);
        d8 = 8'h00;
        for (int n = 0; n < 65537; n++) tick();
        chk("cnt_sat", 64'(empty_cnt8), 64'hFFFF);
`endif

        in_valid = 1'b0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
